// File: rtl/seq_mul_pkg.sv
// Shared state encoding and helpers for the one-hot shift-and-add multiplier.
package seq_mul_pkg;

  localparam int T0_IDX = 0;
  localparam int T1_IDX = 1;
  localparam int T2_IDX = 2;
  localparam int T3_IDX = 3;

  localparam logic [3:0] T_IDLE = 4'b0001;

  typedef enum logic [3:0] {
    ST_IDLE  = 4'b0001,
    ST_ADD   = 4'b0010,
    ST_SHIFT = 4'b0100,
    ST_DONE  = 4'b1000
  } state_e;

  function automatic logic is_onehot(input logic [3:0] t);
    return (t != 4'b0000) && ((t & (t - 4'd1)) == 4'b0000);
  endfunction

endpackage

// File: rtl/mul_onehot_ctrl.sv
// One-hot ASM controller: one flip-flop per state, sum-of-products next state,
// and any non-one-hot state falls back to idle.
module mul_onehot_ctrl
  import seq_mul_pkg::*;
(
  input  logic       CLK,
  input  logic       RST_N,
  input  logic       S,
  input  logic       X,
  input  logic       Z,
  output logic [3:0] T,
  output logic       load,
  output logic       add,
  output logic       shift,
  output logic       done
);

  logic [3:0] t_r;
  logic [3:0] t_next_s;
  logic       legal_s;

  // Legality of the current state vector
  always_comb begin
    legal_s = is_onehot(t_r);
  end

  // Next-state equations; illegal encodings recover to idle
  always_comb begin
    t_next_s = T_IDLE;
    if (legal_s) begin
      t_next_s[T0_IDX] = (t_r[T0_IDX] & ~S) | t_r[T3_IDX];
      t_next_s[T1_IDX] = (t_r[T0_IDX] & S) | (t_r[T2_IDX] & ~Z);
      t_next_s[T2_IDX] = t_r[T1_IDX];
      t_next_s[T3_IDX] = t_r[T2_IDX] & Z;
    end else begin
      t_next_s = T_IDLE;
    end
  end

  // State register
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      t_r <= T_IDLE;
    end else begin
      t_r <= t_next_s;
    end
  end

  // Datapath strobes, all suppressed while the state is illegal
  always_comb begin
    T     = t_r;
    load  = legal_s & t_r[T0_IDX] & S;
    add   = legal_s & t_r[T1_IDX] & X;
    shift = legal_s & t_r[T2_IDX];
    done  = legal_s & t_r[T3_IDX];
  end

endmodule

// File: rtl/seq_shift_add_mul.sv
// Sequential unsigned shift-and-add multiplier: W add/shift iterations per
// operation under a one-hot controller, with a start/done handshake.
module seq_shift_add_mul
  import seq_mul_pkg::*;
#(
  parameter int W = 8
) (
  input  logic           CLK,
  input  logic           RST_N,
  input  logic           S,
  input  logic [W-1:0]   A,
  input  logic [W-1:0]   B,
  output logic [2*W-1:0] P,
  output logic           BUSY,
  output logic           DONE,
  output logic [3:0]     T
);

  localparam int CW = $clog2(W + 1);

  logic [W-1:0]   m_r;
  logic [W-1:0]   q_r;
  logic [W:0]     acc_r;
  logic [CW-1:0]  cnt_r;
  logic [2*W-1:0] p_r;

  logic           x_s;
  logic           z_s;
  logic           load_s;
  logic           add_s;
  logic           shift_s;
  logic           done_s;
  logic [3:0]     t_s;
  logic [W:0]     acc_add_s;
  logic [W:0]     acc_sh_s;
  logic [W-1:0]   q_sh_s;

  // Loop condition inputs for the controller
  always_comb begin
    x_s = q_r[0];
    z_s = (cnt_r == CW'(1));
  end

  // Add and shift candidates; the add result keeps its carry in ACC[W]
  always_comb begin
    acc_add_s            = {1'b0, acc_r[W-1:0]} + {1'b0, m_r};
    {acc_sh_s, q_sh_s}   = {1'b0, acc_r, q_r[W-1:1]};
  end

  mul_onehot_ctrl u_ctrl (
    .CLK   (CLK),
    .RST_N (RST_N),
    .S     (S),
    .X     (x_s),
    .Z     (z_s),
    .T     (t_s),
    .load  (load_s),
    .add   (add_s),
    .shift (shift_s),
    .done  (done_s)
  );

  // Operand, accumulator and iteration counter registers
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      m_r   <= {W{1'b0}};
      q_r   <= {W{1'b0}};
      acc_r <= {(W+1){1'b0}};
      cnt_r <= {CW{1'b0}};
    end else if (load_s) begin
      m_r   <= A;
      q_r   <= B;
      acc_r <= {(W+1){1'b0}};
      cnt_r <= CW'(W);
    end else if (add_s) begin
      acc_r <= acc_add_s;
    end else if (shift_s) begin
      acc_r <= acc_sh_s;
      q_r   <= q_sh_s;
      cnt_r <= cnt_r - CW'(1);
    end
  end

  // Product captured on the final shift so it is already valid while DONE is high
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      p_r <= {(2*W){1'b0}};
    end else if (shift_s && z_s) begin
      p_r <= {acc_sh_s[W-1:0], q_sh_s};
    end
  end

  // Status decoded from the registered state only
  always_comb begin
    P    = p_r;
    T    = t_s;
    BUSY = is_onehot(t_s) & ~t_s[T0_IDX];
    DONE = done_s;
  end

endmodule

// File: tb/tb_seq_shift_add_mul.sv
// Randomised self-checking bench for seq_shift_add_mul against a cycle-count model.
module tb_seq_shift_add_mul;
  import seq_mul_pkg::*;

  localparam int W = 8;

  logic           CLK   = 1'b0;
  logic           RST_N = 1'b0;
  logic           S     = 1'b0;
  logic [W-1:0]   A     = '0;
  logic [W-1:0]   B     = '0;
  logic [2*W-1:0] P;
  logic           BUSY;
  logic           DONE;
  logic [3:0]     T;

  logic           S4 = 1'b0;
  logic [3:0]     A4 = 4'd0;
  logic [3:0]     B4 = 4'd0;
  logic [7:0]     P4;
  logic           BUSY4;
  logic           DONE4;
  logic [3:0]     T4;

  int checks   = 0;
  int failures = 0;
  bit chk_en   = 1'b0;
  int cyc      = 0;

  always #5 CLK = ~CLK;

  always @(posedge CLK) cyc <= cyc + 1;

  seq_shift_add_mul #(.W(W)) dut (
    .CLK(CLK), .RST_N(RST_N), .S(S), .A(A), .B(B),
    .P(P), .BUSY(BUSY), .DONE(DONE), .T(T)
  );

  seq_shift_add_mul #(.W(4)) dut4 (
    .CLK(CLK), .RST_N(RST_N), .S(S4), .A(A4), .B(B4),
    .P(P4), .BUSY(BUSY4), .DONE(DONE4), .T(T4)
  );

  // Reference: an accepted start makes the unit busy for 2W+1 cycles, the last one
  // being DONE with P = A*B; T alternates ADD/SHIFT before that.
  int             rem;
  logic [2*W-1:0] pend;
  logic [2*W-1:0] exp_p;

  always @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      rem   <= 0;
      pend  <= '0;
      exp_p <= '0;
    end else if (rem == 0) begin
      if (S) begin
        rem  <= 2*W + 1;
        pend <= (2*W)'(A) * (2*W)'(B);
      end
    end else begin
      rem <= rem - 1;
      if (rem == 2) exp_p <= pend;
    end
  end

  function automatic logic [3:0] exp_t(input int r);
    if (r == 0) return ST_IDLE;
    if (r == 1) return ST_DONE;
    if ((r % 2) == 1) return ST_ADD;
    return ST_SHIFT;
  endfunction

  task automatic chk(input string name, input longint act, input longint expv);
    checks++;
    if (act != expv) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d (t=%0t)", name, act, expv, $time);
    end
  endtask

  always @(negedge CLK) begin
    if (RST_N && chk_en) begin
      chk("cyc_P",    longint'(P),    longint'(exp_p));
      chk("cyc_BUSY", longint'(BUSY), longint'(rem != 0));
      chk("cyc_DONE", longint'(DONE), longint'(rem == 1));
      chk("cyc_T",    longint'(T),    longint'(exp_t(rem)));
    end
  end

  task automatic do_op(input logic [W-1:0] a, input logic [W-1:0] b,
                       input longint expv, input bit scramble);
    int lat;
    int busy;
    bit seen;
    @(negedge CLK);
    A = a; B = b; S = 1'b1;
    lat = 0; busy = 0; seen = 1'b0;
    for (int i = 0; i < 100 && !seen; i++) begin
      @(negedge CLK);
      lat++;
      if (scramble) begin
        S = 1'($urandom_range(0, 1));
        A = W'($urandom);
        B = W'($urandom);
      end else begin
        S = 1'b0;
      end
      if (BUSY) busy++;
      if (DONE) begin
        seen = 1'b1;
        S = 1'b0;
      end
    end
    chk("done_seen",   longint'(seen), 64'd1);
    chk("latency",     longint'(lat),  longint'(2*W + 1));
    chk("busy_cycles", longint'(busy), longint'(2*W + 1));
    chk("product",     longint'(P),    expv);
  endtask

  task automatic wait_done(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 100 && !ok; i++) begin
      @(negedge CLK);
      if (DONE) ok = 1'b1;
    end
    if (!ok) chk("wait_done_timeout", 64'd0, 64'd1);
  endtask

  initial begin
    bit ok;
    int t1;
    int t2;
    int lat4;
    logic [W-1:0] ra;
    logic [W-1:0] rb;

    #12;
    chk("rst_T",    longint'(T),    longint'(4'b0001));
    chk("rst_P",    longint'(P),    64'd0);
    chk("rst_BUSY", longint'(BUSY), 64'd0);
    chk("rst_DONE", longint'(DONE), 64'd0);
    chk("rst_T4",   longint'(T4),   longint'(4'b0001));
    @(negedge CLK);
    RST_N = 1'b1;
    chk_en = 1'b1;

    do_op(8'd13, 8'd11, 64'd143, 1'b0);
    chk("model_13x11", longint'(exp_p), 64'd143);
    do_op(8'd255, 8'd255, 64'd65025, 1'b0);
    chk("model_255x255", longint'(exp_p), 64'd65025);
    do_op(8'd0, 8'd200, 64'd0, 1'b0);

    // Start held high: back-to-back operations
    @(negedge CLK);
    A = 8'd7; B = 8'd9; S = 1'b1;
    wait_done(ok);
    t1 = cyc;
    chk("b2b_first", longint'(P), 64'd63);
    A = 8'd100; B = 8'd3;
    wait_done(ok);
    t2 = cyc;
    S = 1'b0;
    chk("b2b_second", longint'(P), 64'd300);
    chk("b2b_period", longint'(t2 - t1), longint'(2*W + 2));
    repeat (2) @(negedge CLK);

    // Asynchronous reset in the middle of an operation
    @(negedge CLK);
    A = 8'd200; B = 8'd201; S = 1'b1;
    @(negedge CLK);
    S = 1'b0;
    ok = 1'b0;
    for (int i = 0; i < 20 && !ok; i++) begin
      if (T == ST_SHIFT) ok = 1'b1;
      else @(negedge CLK);
    end
    chk("reach_T2", longint'(ok), 64'd1);
    RST_N = 1'b0;
    #1;
    chk("abort_T",    longint'(T),    longint'(4'b0001));
    chk("abort_P",    longint'(P),    64'd0);
    chk("abort_BUSY", longint'(BUSY), 64'd0);
    chk("abort_DONE", longint'(DONE), 64'd0);
    @(negedge CLK);
    RST_N = 1'b1;
    do_op(8'd200, 8'd201, 64'd40200, 1'b0);

    // Random operands with S/A/B disturbed while busy
    for (int n = 0; n < 20; n++) begin
      ra = W'($urandom);
      rb = W'($urandom);
      do_op(ra, rb, longint'(ra) * longint'(rb), 1'b1);
    end
    do_op(8'd255, 8'd1, 64'd255, 1'b1);

    // Illegal state recovery
    @(negedge CLK);
    chk_en = 1'b0;
    force dut.u_ctrl.t_r = 4'b0110;
    #1;
    chk("illegal_DONE", longint'(DONE), 64'd0);
    #1;
    release dut.u_ctrl.t_r;
    @(posedge CLK);
    #1;
    chk("recover_T",    longint'(T),    longint'(4'b0001));
    chk("recover_DONE", longint'(DONE), 64'd0);
    chk("recover_P",    longint'(P),    64'd255);
    #2;
    chk_en = 1'b1;
    do_op(8'd17, 8'd15, 64'd255, 1'b0);

    // Narrow build
    @(negedge CLK);
    A4 = 4'd15; B4 = 4'd15; S4 = 1'b1;
    lat4 = 0;
    ok = 1'b0;
    for (int i = 0; i < 50 && !ok; i++) begin
      @(negedge CLK);
      S4 = 1'b0;
      lat4++;
      if (DONE4) ok = 1'b1;
    end
    chk("w4_latency", longint'(lat4), 64'd9);
    chk("w4_product", longint'(P4),   64'd225);

    repeat (3) @(negedge CLK);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
